// File: rtl/prog_loader.sv
// Program-memory loader: receives a length-prefixed byte stream, assembles
// big-endian 32-bit words, writes them to program memory and holds the core.
module prog_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_err,
   output logic [15:0]           words_written
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   // Words available from BASE_ADDR to the top of memory; 17 bits so a full
   // 64K-word memory is representable.
   localparam logic [16:0] ROOM = 17'((1 << ADDR_WIDTH) - BASE_ADDR);

   logic [2:0]  state;
   logic [2:0]  next_state;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] shreg;
   logic [31:0] addr_sum;
   logic        accept;
   logic        can_start;
   logic        last_byte;

   assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
   assign accept    = in_valid && in_ready;
   assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
   assign len_full  = {len[15:8], in_byte};
   assign last_byte = (byte_idx == 2'd3) && (word_idx == len - 16'd1);
   assign addr_sum  = 32'(BASE_ADDR) + {16'd0, word_idx};

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_HI;
         S_LEN_HI:              if (accept) next_state = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0)               next_state = S_DONE;
               else if ({1'b0, len_full} > ROOM)    next_state = S_ERR;
               else                                 next_state = S_DATA;
            end
         end
         S_DATA:                if (accept && last_byte) next_state = S_DONE;
         default:               next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is
   // synchronous and also clears the datapath so no partial word survives it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         len           <= 16'd0;
         word_idx      <= 16'd0;
         byte_idx      <= 2'd0;
         shreg         <= 24'd0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= 32'd0;
         cpu_hold      <= 1'b1;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         words_written <= 16'd0;
      end else begin
         state     <= next_state;
         mem_we    <= 1'b0;
         load_done <= (next_state == S_DONE);
         load_err  <= (next_state == S_ERR);
         // Release the core one cycle after DONE is entered; a restart re-asserts at once.
         cpu_hold  <= !((state == S_DONE) && !start);

         if (can_start && start) words_written <= 16'd0;

         case (state)
            S_LEN_HI: if (accept) len[15:8] <= in_byte;
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= in_byte;
                  byte_idx <= 2'd0;
                  word_idx <= 16'd0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  shreg    <= {shreg[15:0], in_byte};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     mem_we        <= 1'b1;
                     mem_addr      <= addr_sum[ADDR_WIDTH-1:0];
                     mem_wdata     <= {shreg, in_byte};
                     word_idx      <= word_idx + 16'd1;
                     words_written <= words_written + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0 and base 8) share one stimulus;
// expected writes come from the frame contents, checked as they appear.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'd0;

   logic        ready0, we0, hold0, done0, err0;
   logic [9:0]  addr0;
   logic [31:0] wdata0;
   logic [15:0] ww0;
   logic        ready8, we8, hold8, done8, err8;
   logic [9:0]  addr8;
   logic [31:0] wdata8;
   logic [15:0] ww8;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp0[$];
   wr_t         exp8[$];
   wr_t         e0, e8;
   int          we_cyc0[$];
   logic [31:0] words[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;

   prog_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
      .cpu_hold(hold0), .load_done(done0), .load_err(err0), .words_written(ww0)
   );

   prog_loader #(.ADDR_WIDTH(10), .BASE_ADDR(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(ready8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
      .cpu_hold(hold8), .load_done(done8), .load_err(err8), .words_written(ww8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the next expected (addr, data) for that instance.
   always @(negedge clk) begin
      if (we0) begin
         check("we0_expected", 32'(exp0.size() > 0), 32'd1);
         if (exp0.size() > 0) begin
            e0 = exp0.pop_front();
            check("addr0", 32'(addr0), 32'(e0.addr));
            check("data0", wdata0, e0.data);
         end
         we_cyc0.push_back(cyc);
      end
      if (we8) begin
         check("we8_expected", 32'(exp8.size() > 0), 32'd1);
         if (exp8.size() > 0) begin
            e8 = exp8.pop_front();
            check("addr8", 32'(addr8), 32'(e8.addr));
            check("data8", wdata8, e8.data);
         end
      end
   end

   function automatic int gap_of(input int mode);
      if (mode == 1) return 1;
      if (mode == 2) return int'($urandom_range(0, 2));
      return 0;
   endfunction

   function automatic logic [7:0] get_byte(input int k);
      logic [31:0] w;
      w = words[k / 4];
      return w[31 - 8 * (k % 4) -: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte, wait (bounded) for acceptance, then idle for gap cycles.
   task automatic put(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_byte  = b;
      while (!ready0 && n < 40) begin
         tick();
         n++;
      end
      if (!ready0) check("ready_timeout", 32'(ready0), 32'd1);
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode: 0 full rate, 1 valid every other cycle, 2 random gaps, 3 start held during data.
   task automatic load_words(input int mode);
      int n;
      int total;
      n = words.size();
      total = 4 * n;
      for (int i = 0; i < n; i++) begin
         exp0.push_back({10'(i), words[i]});
         exp8.push_back({10'(8 + i), words[i]});
      end
      put(8'(n >> 8), 0);
      put(8'(n), (total == 0) ? 0 : gap_of(mode));
      for (int k = 0; k < total; k++) begin
         start = (mode == 3) && (k != total - 1);
         put(get_byte(k), (k == total - 1) ? 0 : gap_of(mode));
      end
      start = 1'b0;
   endtask

   // Called in the cycle after the last frame byte was accepted.
   task automatic finish_check(input int n);
      check("done0_c1", 32'(done0), 32'd1);
      check("done8_c1", 32'(done8), 32'd1);
      check("final_we0", 32'(we0), 32'(n != 0));
      check("hold0_c1", 32'(hold0), 32'd1);
      check("ready0_done", 32'(ready0), 32'd0);
      check("ww0_c1", 32'(ww0), 32'(n));
      tick();
      check("hold0_c2", 32'(hold0), 32'd0);
      check("hold8_c2", 32'(hold8), 32'd0);
      check("ww0_c2", 32'(ww0), 32'(n));
      check("ww8_c2", 32'(ww8), 32'(n));
      check("pending0", 32'(exp0.size()), 32'd0);
      check("pending8", 32'(exp8.size()), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, 32'(ready0), 32'd0);
      check({tag, "_we"}, 32'(we0 | we8), 32'd0);
      check({tag, "_addr"}, 32'(addr0), 32'd0);
      check({tag, "_wdata"}, wdata0, 32'd0);
      check({tag, "_hold"}, 32'(hold0 & hold8), 32'd1);
      check({tag, "_done"}, 32'(done0 | done8), 32'd0);
      check({tag, "_err"}, 32'(err0 | err8), 32'd0);
      check({tag, "_ww"}, 32'(ww0), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset("rst");
      rst_n = 1'b1;
      tick();
      check("idle_ready", 32'(ready0), 32'd0);
      check("idle_hold", 32'(hold0), 32'd1);

      // Two-word frame at full rate
      pulse_start();
      check("start_hold", 32'(hold0), 32'd1);
      we_cyc0.delete();
      words = '{32'h2008_0005, 32'hAC01_0004};
      load_words(0);
      finish_check(2);
      check("we_spacing", 32'(we_cyc0[1] - we_cyc0[0]), 32'd4);

      // Same frame, in_valid every other cycle; restart from DONE
      pulse_start();
      check("restart_hold", 32'(hold0), 32'd1);
      check("restart_done", 32'(done0), 32'd0);
      check("restart_ww", 32'(ww0), 32'd0);
      load_words(1);
      finish_check(2);

      // Single word (lands at address 8 in the base-8 instance)
      pulse_start();
      words = '{32'hFC00_0000};
      load_words(0);
      finish_check(1);

      // Length 0x0401 exceeds both memories
      pulse_start();
      put(8'h04, 0);
      put(8'h01, 0);
      check("err0", 32'(err0), 32'd1);
      check("err8", 32'(err8), 32'd1);
      check("err_ready", 32'(ready0), 32'd0);
      check("err_hold", 32'(hold0), 32'd1);
      repeat (3) tick();
      check("err_sticky", 32'(err0), 32'd1);
      check("err_hold_late", 32'(hold0), 32'd1);
      pulse_start();
      check("err_cleared", 32'(err0), 32'd0);
      words = '{$urandom()};
      load_words(0);
      finish_check(1);

      // Reset after 6 data bytes of a 2-word frame
      pulse_start();
      words = '{$urandom(), $urandom()};
      exp0.push_back({10'd0, words[0]});
      exp8.push_back({10'd8, words[0]});
      put(8'h00, 0);
      put(8'h02, 0);
      for (int k = 0; k < 6; k++) put(get_byte(k), 0);
      rst_n = 1'b0;
      tick();
      check_reset("midrst");
      check("midrst_pending", 32'(exp0.size()), 32'd0);
      rst_n = 1'b1;
      tick();
      pulse_start();
      words = '{$urandom(), $urandom()};
      load_words(2);
      finish_check(2);

      // start held high during data is ignored
      pulse_start();
      words = '{$urandom(), $urandom(), $urandom()};
      load_words(3);
      finish_check(3);

      // Zero-length frame
      pulse_start();
      words.delete();
      load_words(0);
      finish_check(0);

      // Random frames with random gaps
      for (int f = 0; f < 3; f++) begin
         pulse_start();
         words.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back($urandom());
         load_words(2);
         finish_check(words.size());
      end

      repeat (4) tick();
      check("tail_pending0", 32'(exp0.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
